// File: rtl/en_reg_pkg.sv
// en_reg_pkg: state encoding and parameter defaults shared by the enable-register arbiter.
package en_reg_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_HOLD_CYC = 2;
endpackage

// File: rtl/en_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set req bit at or after ptr with wrap-around.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/en_reg_arbiter.sv
// en_reg_arbiter: round-robin arbitration of N_REQ writers onto one shared enable register.
module en_reg_arbiter
  import en_reg_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qbar,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);
  localparam logic [3:0] HOLD_M1 = HOLD_CYC == 0 ? 4'd0 : 4'(HOLD_CYC - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  logic [1:0] state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [3:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, qbar_q, qbar_d, slice;
  logic pick_valid, win;
  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );
  assign slice = wdata[int'(owner_q)*WIDTH +: WIDTH];
  assign win   = state_q == S_GRANT && req[owner_q];
  // reset gating keeps a write that is being discarded from ever showing a grant
  assign gnt   = (win && !rst) ? ONE << owner_q : '0;
  assign busy  = state_q == S_GRANT || state_q == S_HOLD;
  assign q     = q_q;
  assign qbar  = qbar_q;
  assign owner = owner_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    qbar_d  = qbar_q;
    if (state_q == S_IDLE && pick_valid) begin
      state_d = S_GRANT;
      owner_d = pick_idx;
    end
    if (state_q == S_GRANT) begin
      state_d = (win && HOLD_CYC != 0) ? S_HOLD : S_IDLE;
      cnt_d   = (win && HOLD_CYC != 0) ? HOLD_M1 : 4'd0;
      q_d     = win ? slice : q_q;
      qbar_d  = win ? ~slice : qbar_q;
      ptr_d   = win ? (owner_q == LAST ? '0 : owner_q + 1'b1) : ptr_q;
    end
    if (state_q == S_HOLD) begin
      state_d = cnt_q == 4'd0 ? S_IDLE : S_HOLD;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= 4'd0;
      q_q     <= '0;
      qbar_q  <= '1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qbar_q  <= qbar_d;
    end
  end
endmodule

// File: tb/tb_en_reg_arbiter.sv
// tb_en_reg_arbiter: directed checks of en_reg_arbiter with HOLD_CYC=2 and HOLD_CYC=0 instances.
module tb_en_reg_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, req0 = '0, gnt, gnt0;
  logic [31:0] wd = '0, wd0 = '0;
  logic [7:0] q, qbar, q0, qbar0, exp_q;
  logic [3:0] exp_g;
  logic busy, busy0;
  logic [1:0] owner, owner0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  en_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wd), .gnt(gnt),
    .q(q), .qbar(qbar), .busy(busy), .owner(owner)
  );
  en_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .wdata(wd0), .gnt(gnt0),
    .q(q0), .qbar(qbar0), .busy(busy0), .owner(owner0)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1; req = '0; req0 = '0;
    step;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; req = 4'hf; wd = 32'hffff_ffff;
    step; step;
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q got %h want 00", q); end
    tests++; if (qbar !== 8'hff) begin fails++; $display("FAIL reset_qbar got %h want ff", qbar); end
    tests++; if (gnt !== 4'h0) begin fails++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (owner !== 2'd0) begin fails++; $display("FAIL reset_owner got %0d want 0", owner); end
    rst = 1'b0; req = '0;
  endtask
  task automatic test_single;
    do_reset;
    wd = 32'h00a5_0000; req = 4'b0100;
    #1;
    tests++; if (gnt !== 4'h0) begin fails++; $display("FAIL single_idle_gnt got %b want 0000", gnt); end
    step;
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt got %b want 0100", gnt); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", busy); end
    step;
    req = '0;
    tests++; if (q !== 8'ha5) begin fails++; $display("FAIL single_q got %h want a5", q); end
    tests++; if (qbar !== 8'h5a) begin fails++; $display("FAIL single_qbar got %h want 5a", qbar); end
    tests++; if (gnt !== 4'h0) begin fails++; $display("FAIL single_gnt_drop got %b want 0000", gnt); end
  endtask
  task automatic test_round_robin;
    do_reset;
    wd = 32'h1312_1110; req = 4'hf;
    for (int k = 0; k < 18; k++) begin
      #1;
      exp_g = (k % 4 == 1) ? 4'(1 << ((k / 4) % 4)) : 4'h0;
      tests++; if (gnt !== exp_g) begin fails++; $display("FAIL rr_gnt k=%0d got %b want %b", k, gnt, exp_g); end
      if (k % 4 == 2) begin
        exp_q = 8'h10 + 8'((k / 4) % 4);
        tests++; if (q !== exp_q) begin fails++; $display("FAIL rr_q k=%0d got %h want %h", k, q, exp_q); end
        tests++; if (qbar !== ~exp_q) begin fails++; $display("FAIL rr_qbar k=%0d got %h want %h", k, qbar, ~exp_q); end
      end
      step;
    end
    req = '0;
  endtask
  task automatic test_wrap;
    logic [3:0] req_t [10] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0101,
                                4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
    logic [3:0] gnt_t [10] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                                4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    do_reset;
    wd = 32'h0000_0000;
    for (int k = 0; k < 10; k++) begin
      req = req_t[k];
      #1;
      tests++; if (gnt !== gnt_t[k]) begin fails++; $display("FAIL wrap_gnt k=%0d got %b want %b", k, gnt, gnt_t[k]); end
      step;
    end
    req = '0;
  endtask
  task automatic test_withdraw;
    do_reset;
    wd = 32'h0000_773c; req = 4'b0001;
    step; step;
    req = '0;
    step; step;
    req = 4'b0010;
    #1;
    tests++; if (gnt !== 4'h0) begin fails++; $display("FAIL wd_idle_gnt got %b want 0000", gnt); end
    step;
    req = '0;
    #1;
    tests++; if (gnt !== 4'h0) begin fails++; $display("FAIL wd_gnt got %b want 0000", gnt); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wd_busy got %b want 1", busy); end
    tests++; if (owner !== 2'd1) begin fails++; $display("FAIL wd_owner got %0d want 1", owner); end
    step;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wd_idle_busy got %b want 0", busy); end
    tests++; if (q !== 8'h3c) begin fails++; $display("FAIL wd_q got %h want 3c", q); end
    req = 4'hf;
    step;
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL wd_ptr_gnt got %b want 0010", gnt); end
    req = '0;
  endtask
  task automatic test_reset_mid;
    do_reset;
    wd = 32'h0000_00ff; req = 4'b0001;
    step;
    rst = 1'b1;
    #1;
    tests++; if (gnt !== 4'h0) begin fails++; $display("FAIL rmid_gnt got %b want 0000", gnt); end
    step;
    rst = 1'b0; req = '0;
    #1;
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL rmid_q got %h want 00", q); end
    tests++; if (qbar !== 8'hff) begin fails++; $display("FAIL rmid_qbar got %h want ff", qbar); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end
    tests++; if (gnt !== 4'h0) begin fails++; $display("FAIL rmid_gnt_after got %b want 0000", gnt); end
  endtask
  task automatic test_hold0;
    do_reset;
    wd0 = 32'h0000_bbaa; req0 = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      #1;
      exp_g = (k % 2 == 1) ? 4'(1 << ((k / 2) % 2)) : 4'h0;
      tests++; if (gnt0 !== exp_g) begin fails++; $display("FAIL h0_gnt k=%0d got %b want %b", k, gnt0, exp_g); end
      tests++; if (busy0 !== (k % 2 == 1)) begin fails++; $display("FAIL h0_busy k=%0d got %b want %b", k, busy0, k % 2 == 1); end
      if (k >= 2 && k % 2 == 0) begin
        exp_q = (k % 4 == 2) ? 8'haa : 8'hbb;
        tests++; if (q0 !== exp_q) begin fails++; $display("FAIL h0_q k=%0d got %h want %h", k, q0, exp_q); end
      end
      step;
    end
    req0 = '0;
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_wrap;
    test_withdraw;
    test_reset_mid;
    test_hold0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/en_reg_arbiter.md
EN_REG_ARBITER -- requirements
Module: en_reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the register, range 2..8.
REQ-002 Parameter WIDTH, default 8: width of the shared enable register.
REQ-003 Parameter HOLD_CYC, default 2: dead cycles after each write before the next arbitration, range 0..15.
REQ-004 clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 req  input  N_REQ: write request, one bit per requester.
REQ-007 wdata  input  N_REQ*WIDTH: write data; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-008 gnt  output  N_REQ: one-hot, one-cycle grant pulse marking the cycle the write occurs.
REQ-009 q  output  WIDTH: shared register contents.
REQ-010 qbar  output  WIDTH: bitwise complement of q.
REQ-011 busy  output  1: arbiter is in GRANT or HOLD.
REQ-012 owner  output  clog2(N_REQ): index of the current or last winner.

Function
REQ-013 FSM states: IDLE, GRANT, HOLD.
REQ-014 IDLE, any req bit high: latch the round-robin winner into owner; go to GRANT next cycle.
REQ-015 Winner = first requester with req high, searching ptr, ptr+1, ... with wrap-around modulo N_REQ.
REQ-016 GRANT with req[owner] still high: gnt[owner]=1 for this cycle only; q <= wdata slice of owner; ptr <= (owner+1) mod N_REQ.
REQ-017 GRANT with req[owner] low (withdrawn): abort; no gnt, q unchanged, ptr unchanged; return to IDLE.
REQ-018 After a completed GRANT: go to HOLD for exactly HOLD_CYC cycles, then IDLE; with HOLD_CYC=0, go directly to IDLE.
REQ-019 req is ignored in GRANT (except REQ-017) and in HOLD; no request is queued.
REQ-020 Requester handshake: hold req and wdata stable until its gnt pulse; drop req the cycle after gnt, or it re-competes.
REQ-021 Latency: req rises in IDLE in cycle t; gnt high in cycle t+1; new q visible from cycle t+2.
REQ-022 Minimum spacing between consecutive grants: 2+HOLD_CYC cycles.
REQ-023 qbar is registered together with q, so qbar == ~q holds in every cycle.
REQ-024 busy=1 exactly in GRANT and HOLD; owner holds its value outside GRANT.
REQ-025 gnt is never multi-hot; gnt is never asserted in IDLE or HOLD.

Reset
REQ-026 rst sampled high at a rising edge: state=IDLE, q=0, qbar=all ones, gnt=0, busy=0, owner=0, ptr=0, hold counter=0.
REQ-027 rst overrides every state, including mid-GRANT; a write in progress is discarded, with no gnt and q=0.
REQ-028 First arbitration after reset starts at requester 0.

Structure
REQ-029 Shared package en_reg_pkg holds the state encoding (IDLE/GRANT/HOLD) and the default values of N_REQ, WIDTH and HOLD_CYC.
REQ-030 One sub-module, rr_pick: combinational round-robin selector taking req and ptr, returning a valid flag and the winner index.
REQ-031 All other logic (FSM, hold counter, ptr, q/qbar register) lives in en_reg_arbiter.

Verification
REQ-032 Single request: reset; req=4'b0100, wdata slice2=8'hA5 -> gnt=4'b0100 one cycle later; q=8'hA5 and qbar=8'h5A the cycle after.
REQ-033 Round-robin: req=4'b1111 held, HOLD_CYC=2 -> grant order 0,1,2,3,0; grants exactly 4 cycles apart.
REQ-034 Wrap-around: ptr=3 (last winner 2); req=4'b0101 -> requester 0 wins; next grant goes to 2.
REQ-035 Withdrawal: req[1] pulsed for one cycle in IDLE -> GRANT aborts, no gnt, q unchanged, ptr unchanged, back to IDLE.
REQ-036 Reset mid-operation: rst high in the GRANT cycle with wdata=8'hFF -> next cycle q=0, qbar=8'hFF, busy=0, gnt=0.
REQ-037 HOLD_CYC=0: req=4'b0011 held -> grants alternate 0,1 every 2 cycles; gnt always one-hot and busy correct throughout.
